// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: access-size codes, bus FSM states,
// the EX/MEM pipeline register layout and the alignment rule.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_e;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic        vld;
        logic [31:0] alu_res;
        logic [31:0] din;
        logic        rd;
        logic        wr;
        mem_size_e   size;
        logic        uns;
        logic        reg_wr;
        logic [4:0]  dest;
    } ex_mem_t;

    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] a);
        return ((size == MEM_HALF) && a[0]) || ((size == MEM_WORD) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension
// for loads, driven by access size and the low address bits.
module mem_align
    import mem_stage_pkg::*;
(
    input  mem_size_e   size,
    input  logic        uns,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] din,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    assign byte_val = rdata[{addr_lo, 3'b000} +: 8];
    // Half accesses select lanes from a[1] alone, so a[0] never shifts data.
    assign half_val = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // NOTE: every output gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        be        = 4'hF;
        wdata     = din;
        load_data = rdata;
        case (size)
            MEM_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{din[7:0]}};
                load_data = {{24{byte_val[7] & ~uns}}, byte_val};
            end
            MEM_HALF: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata     = {2{din[15:0]}};
                load_data = {{16{half_val[15] & ~uns}}, half_val};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX/MEM register, req/ack data-memory port FSM
// and stall generation. Optional misaligned-access drop: MEM_MISALIGN_CHK_EN.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_alu_res,
    input  logic [31:0] EX_mem_din,
    input  logic        EX_vld,
    input  logic        EX_alu_busy,
    input  logic        EX_mem_rd,
    input  logic        EX_mem_wr,
    input  logic [1:0]  EX_mem_size,
    input  logic        EX_mem_uns,
    input  logic        EX_reg_wr,
    input  logic [4:0]  EX_dest_reg,
    output logic        Dmem_req,
    output logic        Dmem_we,
    output logic [31:0] Dmem_addr,
    output logic [3:0]  Dmem_be,
    output logic [31:0] Dmem_wdata,
    input  logic        Dmem_ack,
    input  logic [31:0] Dmem_rdata,
    output logic [31:0] MEM_data,
    output logic        MEM_vld,
    output logic        MEM_reg_wr,
    output logic [4:0]  MEM_dest_reg,
    output logic        MEM_busy,
    output logic        MEM_misalign
);

    ex_mem_t    r;
    mem_state_e state, state_nxt;
    logic       misalign, mem_op, req, busy;
    logic [3:0] be;
    logic [31:0] load_data;

`ifdef MEM_MISALIGN_CHK_EN
    assign misalign = r.vld && (r.rd || r.wr) && is_misaligned(r.size, r.alu_res[1:0]);
`else
    assign misalign = 1'b0;
`endif

    assign mem_op = r.vld && (r.rd || r.wr) && !misalign;

    always_comb begin
        state_nxt = state;
        req       = mem_op;
        case (state)
            MEM_IDLE: if (req && !Dmem_ack) state_nxt = MEM_WAIT;
            MEM_WAIT: begin
                req = 1'b1;
                if (Dmem_ack) state_nxt = MEM_IDLE;
            end
            default: state_nxt = MEM_IDLE;
        endcase
    end

    assign busy = req && !Dmem_ack;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MEM_IDLE;
            r     <= '0;
        end else begin
            state <= state_nxt;
            if (!busy) begin
                r.vld     <= EX_vld && !EX_alu_busy;
                r.alu_res <= EX_alu_res;
                r.din     <= EX_mem_din;
                r.rd      <= EX_mem_rd;
                r.wr      <= EX_mem_wr;
                r.size    <= mem_size_e'(EX_mem_size);
                r.uns     <= EX_mem_uns;
                r.reg_wr  <= EX_reg_wr;
                r.dest    <= EX_dest_reg;
            end
        end
    end

    mem_align u_align (
        .size      (r.size),
        .uns       (r.uns),
        .addr_lo   (r.alu_res[1:0]),
        .din       (r.din),
        .rdata     (Dmem_rdata),
        .be        (be),
        .wdata     (Dmem_wdata),
        .load_data (load_data)
    );

    assign Dmem_req     = req;
    assign Dmem_we      = req && r.wr;
    assign Dmem_be      = req ? be : 4'h0;
    assign Dmem_addr    = {r.alu_res[31:2], 2'b00};
    assign MEM_data     = r.rd ? load_data : r.alu_res;
    assign MEM_vld      = r.vld && !busy && !misalign;
    // Stores never write rd even if execute flagged reg_wr.
    assign MEM_reg_wr   = MEM_vld && r.reg_wr && !r.wr;
    assign MEM_dest_reg = r.dest;
    assign MEM_busy     = busy;
    assign MEM_misalign = misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; inputs change on the falling edge
// and outputs are sampled 1 time unit later, well away from the rising edge.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [31:0] EX_alu_res, EX_mem_din;
    logic        EX_vld, EX_alu_busy, EX_mem_rd, EX_mem_wr, EX_mem_uns, EX_reg_wr;
    logic [1:0]  EX_mem_size;
    logic [4:0]  EX_dest_reg;
    logic        Dmem_req, Dmem_we, Dmem_ack;
    logic [31:0] Dmem_addr, Dmem_wdata, Dmem_rdata;
    logic [3:0]  Dmem_be;
    logic [31:0] MEM_data;
    logic        MEM_vld, MEM_reg_wr, MEM_busy, MEM_misalign;
    logic [4:0]  MEM_dest_reg;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .EX_alu_res   (EX_alu_res),
        .EX_mem_din   (EX_mem_din),
        .EX_vld       (EX_vld),
        .EX_alu_busy  (EX_alu_busy),
        .EX_mem_rd    (EX_mem_rd),
        .EX_mem_wr    (EX_mem_wr),
        .EX_mem_size  (EX_mem_size),
        .EX_mem_uns   (EX_mem_uns),
        .EX_reg_wr    (EX_reg_wr),
        .EX_dest_reg  (EX_dest_reg),
        .Dmem_req     (Dmem_req),
        .Dmem_we      (Dmem_we),
        .Dmem_addr    (Dmem_addr),
        .Dmem_be      (Dmem_be),
        .Dmem_wdata   (Dmem_wdata),
        .Dmem_ack     (Dmem_ack),
        .Dmem_rdata   (Dmem_rdata),
        .MEM_data     (MEM_data),
        .MEM_vld      (MEM_vld),
        .MEM_reg_wr   (MEM_reg_wr),
        .MEM_dest_reg (MEM_dest_reg),
        .MEM_busy     (MEM_busy),
        .MEM_misalign (MEM_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic ex_set(input logic [31:0] alu, input logic [31:0] din, input logic rd,
                          input logic wr, input logic [1:0] size, input logic uns,
                          input logic reg_wr, input logic [4:0] dest);
        EX_vld      = 1'b1;
        EX_alu_res  = alu;
        EX_mem_din  = din;
        EX_mem_rd   = rd;
        EX_mem_wr   = wr;
        EX_mem_size = size;
        EX_mem_uns  = uns;
        EX_reg_wr   = reg_wr;
        EX_dest_reg = dest;
    endtask

    task automatic bubble();
        EX_vld      = 1'b0;
        EX_alu_res  = '0;
        EX_mem_din  = '0;
        EX_mem_rd   = 1'b0;
        EX_mem_wr   = 1'b0;
        EX_mem_size = 2'b00;
        EX_mem_uns  = 1'b0;
        EX_reg_wr   = 1'b0;
        EX_dest_reg = '0;
    endtask

    initial begin
        rst         = 1'b1;
        EX_alu_busy = 1'b0;
        Dmem_ack    = 1'b0;
        Dmem_rdata  = '0;
        bubble();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_req",      Dmem_req,     0);
        check("rst_we",       Dmem_we,      0);
        check("rst_be",       Dmem_be,      0);
        check("rst_addr",     Dmem_addr,    0);
        check("rst_wdata",    Dmem_wdata,   0);
        check("rst_vld",      MEM_vld,      0);
        check("rst_reg_wr",   MEM_reg_wr,   0);
        check("rst_busy",     MEM_busy,     0);
        check("rst_misalign", MEM_misalign, 0);
        check("rst_data",     MEM_data,     0);
        check("rst_dest",     MEM_dest_reg, 0);
        rst = 1'b0;

        // ALU op: result visible the cycle after EX
        @(negedge clk); ex_set(32'h1234, 0, 0, 0, 2'b10, 0, 1, 5'd5);
        @(negedge clk); bubble(); #1;
        check("add_data",   MEM_data,     32'h1234);
        check("add_vld",    MEM_vld,      1);
        check("add_req",    Dmem_req,     0);
        check("add_reg_wr", MEM_reg_wr,   1);
        check("add_dest",   MEM_dest_reg, 5);

        // lb 0x103 with zero-wait ack; lbu queued behind it
        @(negedge clk); ex_set(32'h103, 0, 1, 0, 2'b00, 0, 1, 5'd3);
        @(negedge clk); ex_set(32'h103, 0, 1, 0, 2'b00, 1, 1, 5'd4);
        Dmem_ack = 1'b1; Dmem_rdata = 32'h80FF_FF7F; #1;
        check("lb_req",  Dmem_req,  1);
        check("lb_we",   Dmem_we,   0);
        check("lb_be",   Dmem_be,   4'b1000);
        check("lb_addr", Dmem_addr, 32'h100);
        check("lb_data", MEM_data,  32'hFFFF_FF80);
        check("lb_vld",  MEM_vld,   1);
        check("lb_busy", MEM_busy,  0);
        check("lb_dest", MEM_dest_reg, 3);
        @(negedge clk); ex_set(32'h102, 0, 1, 0, 2'b01, 0, 1, 5'd6); #1;
        check("lbu_data", MEM_data,     32'h0000_0080);
        check("lbu_dest", MEM_dest_reg, 4);
        @(negedge clk); bubble(); Dmem_rdata = 32'h8001_2345; #1;
        check("lh_be",   Dmem_be,  4'b1100);
        check("lh_data", MEM_data, 32'hFFFF_8001);

        // sh at 0x202: lane replication, store never writes rd
        @(negedge clk); ex_set(32'h202, 32'hAAAA_BEEF, 0, 1, 2'b01, 0, 1, 5'd8);
        Dmem_ack = 1'b0; #1;
        check("bubble_vld", MEM_vld, 0);
        @(negedge clk); bubble(); Dmem_ack = 1'b1; #1;
        check("sh_addr",   Dmem_addr,  32'h200);
        check("sh_be",     Dmem_be,    4'b1100);
        check("sh_wdata",  Dmem_wdata, 32'hBEEF_BEEF);
        check("sh_we",     Dmem_we,    1);
        check("sh_vld",    MEM_vld,    1);
        check("sh_reg_wr", MEM_reg_wr, 0);

        // Execute busy inserts a bubble
        @(negedge clk); ex_set(32'h77, 0, 0, 0, 2'b10, 0, 1, 5'd1);
        EX_alu_busy = 1'b1; Dmem_ack = 1'b0;
        @(negedge clk); EX_alu_busy = 1'b0; bubble(); #1;
        check("exbusy_vld",    MEM_vld,    0);
        check("exbusy_reg_wr", MEM_reg_wr, 0);

        // lw 0x40 acked after 3 wait cycles; next op held in EX
        @(negedge clk); ex_set(32'h40, 0, 1, 0, 2'b10, 0, 1, 5'd7);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); ex_set(32'h55, 0, 0, 0, 2'b10, 0, 1, 5'd9);
            EX_alu_busy = (i == 2); Dmem_ack = 1'b0; #1;
            check("lw_wait_busy", MEM_busy,  1);
            check("lw_wait_req",  Dmem_req,  1);
            check("lw_wait_addr", Dmem_addr, 32'h40);
            check("lw_wait_vld",  MEM_vld,   0);
        end
        @(negedge clk); EX_alu_busy = 1'b0; Dmem_ack = 1'b1; Dmem_rdata = 32'hDEAD_BEEF; #1;
        check("lw_ack_busy",   MEM_busy,     0);
        check("lw_ack_vld",    MEM_vld,      1);
        check("lw_ack_data",   MEM_data,     32'hDEAD_BEEF);
        check("lw_ack_dest",   MEM_dest_reg, 7);
        check("lw_ack_reg_wr", MEM_reg_wr,   1);
        @(negedge clk); bubble(); Dmem_ack = 1'b0; #1;
        check("held_data", MEM_data,     32'h55);
        check("held_vld",  MEM_vld,      1);
        check("held_dest", MEM_dest_reg, 9);
        check("held_req",  Dmem_req,     0);

        // Reset while waiting abandons the request; a late ack is ignored
        @(negedge clk); ex_set(32'h80, 32'h11, 0, 1, 2'b10, 0, 0, 5'd0);
        @(negedge clk); bubble(); #1;
        check("sw_wait_busy",  MEM_busy,   1);
        check("sw_wait_we",    Dmem_we,    1);
        check("sw_wait_wdata", Dmem_wdata, 32'h11);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        check("rstw_req",  Dmem_req, 0);
        check("rstw_vld",  MEM_vld,  0);
        check("rstw_busy", MEM_busy, 0);
        @(negedge clk); Dmem_ack = 1'b1; #1;
        check("late_ack_vld",    MEM_vld,    0);
        check("late_ack_reg_wr", MEM_reg_wr, 0);
        check("late_ack_busy",   MEM_busy,   0);
        Dmem_ack = 1'b0;

        // Misaligned word load at 0x41
        @(negedge clk); ex_set(32'h41, 0, 1, 0, 2'b10, 0, 1, 5'd2);
`ifdef MEM_MISALIGN_CHK_EN
        @(negedge clk); bubble(); #1;
        check("mis_req",      Dmem_req,     0);
        check("mis_flag",     MEM_misalign, 1);
        check("mis_vld",      MEM_vld,      0);
        check("mis_reg_wr",   MEM_reg_wr,   0);
        check("mis_busy",     MEM_busy,     0);
        @(negedge clk); #1;
        check("mis_flag_end", MEM_misalign, 0);
        check("mis_req_end",  Dmem_req,     0);
`else
        @(negedge clk); bubble(); Dmem_ack = 1'b1; Dmem_rdata = 32'h1234_5678; #1;
        check("mis_addr", Dmem_addr,    32'h40);
        check("mis_be",   Dmem_be,      4'hF);
        check("mis_data", MEM_data,     32'h1234_5678);
        check("mis_flag", MEM_misalign, 0);
        check("mis_vld",  MEM_vld,      1);
        @(negedge clk); Dmem_ack = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
